// File: rtl/pe_dmem_burst_ctrl_pkg.sv
// Shared types and constants for the PE data-memory burst engine.
// Default widths follow PE_DATA_WIDTH / PE_DMEM_ADDR_WIDTH when those defines are provided.
`ifndef PE_DATA_WIDTH
`define PE_DATA_WIDTH 32
`endif
`ifndef PE_DMEM_ADDR_WIDTH
`define PE_DMEM_ADDR_WIDTH 12
`endif

package pe_dmem_burst_ctrl_pkg;

  localparam int unsigned PE_DATA_WIDTH      = `PE_DATA_WIDTH;
  localparam int unsigned PE_DMEM_ADDR_WIDTH = `PE_DMEM_ADDR_WIDTH;
  localparam int unsigned CMD_LEN_WIDTH      = 8;

  localparam int unsigned RD_FIFO_DEPTH = 2;
  localparam int unsigned RD_FIFO_PTR_W = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned RD_FIFO_CNT_W = $clog2(RD_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } burst_state_e;

endpackage

// File: rtl/pe_dmem_burst_ctrl_rdfifo.sv
// Two-entry synchronous read buffer: head word is presented combinationally,
// push while full is accepted only together with a pop.
module pe_dmem_burst_rdfifo
  import pe_dmem_burst_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iPush,
  input  logic [DATA_WIDTH-1:0]    iPush_Data,
  input  logic                     iPop,
  output logic [DATA_WIDTH-1:0]    oPop_Data,
  output logic [RD_FIFO_CNT_W-1:0] oCount
);

  logic [DATA_WIDTH-1:0]    mem_q [RD_FIFO_DEPTH];
  logic [RD_FIFO_PTR_W-1:0] wr_ptr_q;
  logic [RD_FIFO_PTR_W-1:0] rd_ptr_q;
  logic [RD_FIFO_CNT_W-1:0] count_q;
  logic                     push_en;
  logic                     pop_en;

  always_comb begin
    pop_en  = iPop && (count_q != '0);
    push_en = iPush && ((count_q != RD_FIFO_CNT_W'(RD_FIFO_DEPTH)) || pop_en);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int unsigned i = 0; i < RD_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_ptr_q] <= iPush_Data;
        wr_ptr_q        <= wr_ptr_q + RD_FIFO_PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + RD_FIFO_PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + RD_FIFO_CNT_W'(1);
        2'b01:   count_q <= count_q - RD_FIFO_CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    oPop_Data = mem_q[rd_ptr_q];
    oCount    = count_q;
  end

endmodule

// File: rtl/pe_dmem_burst_ctrl.sv
// Port-A burst engine for the PE data memory: one command, then a write or read stream.
// Optional PE_DMEM_BURST_STRIDE_EN adds iCmd_Stride (address step in words per beat).
module pe_dmem_burst_ctrl
  import pe_dmem_burst_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = PE_DMEM_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = CMD_LEN_WIDTH
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic                  iCmd_Valid,
  output logic                  oCmd_Ready,
  input  logic                  iCmd_Write,
  input  logic [ADDR_WIDTH-1:0] iCmd_Address,
  input  logic [LEN_WIDTH-1:0]  iCmd_Length,
`ifdef PE_DMEM_BURST_STRIDE_EN
  input  logic [7:0]            iCmd_Stride,
`endif
  input  logic                  iWr_Valid,
  output logic                  oWr_Ready,
  input  logic [DATA_WIDTH-1:0] iWr_Data,
  output logic                  oRd_Valid,
  input  logic                  iRd_Ready,
  output logic [DATA_WIDTH-1:0] oRd_Data,
  output logic                  oBusy,
  output logic                  oDone,
  output logic                  oBus_Valid,
  output logic                  oBus_Write_Enable,
  output logic [ADDR_WIDTH-1:0] oBus_Address,
  output logic [DATA_WIDTH-1:0] oBus_Write_Data,
  input  logic [DATA_WIDTH-1:0] iBus_Read_Data
);

  burst_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [LEN_WIDTH-1:0]     remain_q, remain_d;
  logic [LEN_WIDTH-1:0]     issue_rem_q, issue_rem_d;
  logic                     inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]    step;
`ifdef PE_DMEM_BURST_STRIDE_EN
  logic [7:0]               stride_q, stride_d;
`endif

  logic                     wr_hs;
  logic                     rd_issue;
  logic                     rd_pop;
  logic [RD_FIFO_CNT_W:0]   rd_occ;
  logic [RD_FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_WIDTH-1:0]    fifo_data;

  pe_dmem_burst_rdfifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rdfifo (
    .iClk       (iClk),
    .iReset     (iReset),
    .iPush      (inflight_q),
    .iPush_Data (iBus_Read_Data),
    .iPop       (rd_pop),
    .oPop_Data  (fifo_data),
    .oCount     (fifo_count)
  );

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      issue_rem_q <= '0;
      inflight_q  <= 1'b0;
`ifdef PE_DMEM_BURST_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      issue_rem_q <= issue_rem_d;
      inflight_q  <= inflight_d;
`ifdef PE_DMEM_BURST_STRIDE_EN
      stride_q    <= stride_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    issue_rem_d = issue_rem_q;
    inflight_d  = rd_issue;
`ifdef PE_DMEM_BURST_STRIDE_EN
    stride_d    = stride_q;
    step        = ADDR_WIDTH'({stride_q, 2'b00});
`else
    step        = ADDR_WIDTH'(4);
`endif
    case (state_q)
      ST_IDLE: begin
        if (iCmd_Valid) begin
          addr_d      = iCmd_Address & ~ADDR_WIDTH'(3);
          remain_d    = iCmd_Length;
          issue_rem_d = iCmd_Length;
`ifdef PE_DMEM_BURST_STRIDE_EN
          stride_d    = iCmd_Stride;
`endif
          if (iCmd_Length == '0) begin
            state_d = ST_DONE;
          end else if (iCmd_Write) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (wr_hs) begin
          addr_d   = addr_q + step;
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        // Issue and pop track separately: the address runs ahead of the host by up to two words.
        if (rd_issue) begin
          addr_d      = addr_q + step;
          issue_rem_d = issue_rem_q - LEN_WIDTH'(1);
        end
        if (rd_pop) begin
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_hs    = (state_q == ST_WRITE) && iWr_Valid;
    rd_pop   = (state_q == ST_READ) && (fifo_count != '0) && iRd_Ready;
    // Buffered plus in-flight words after this cycle's pop must leave room for a new issue.
    rd_occ   = (RD_FIFO_CNT_W + 1)'(fifo_count) + (RD_FIFO_CNT_W + 1)'(inflight_q)
             - (RD_FIFO_CNT_W + 1)'(rd_pop);
    rd_issue = (state_q == ST_READ) && (issue_rem_q != '0)
             && (rd_occ < (RD_FIFO_CNT_W + 1)'(RD_FIFO_DEPTH));

    oCmd_Ready        = (state_q == ST_IDLE);
    oBusy             = (state_q != ST_IDLE);
    oDone             = (state_q == ST_DONE);
    oWr_Ready         = (state_q == ST_WRITE);
    oBus_Valid        = wr_hs || rd_issue;
    oBus_Write_Enable = wr_hs;
    oBus_Address      = addr_q;
    oBus_Write_Data   = (state_q == ST_WRITE) ? iWr_Data : '0;
    oRd_Valid         = (fifo_count != '0);
    oRd_Data          = fifo_data;
  end

endmodule

// File: tb/tb_pe_dmem_burst_ctrl.sv
// Scoreboard bench for pe_dmem_burst_ctrl; exercises the stride path when
// PE_DMEM_BURST_STRIDE_EN is defined.
module tb_pe_dmem_burst_ctrl;

  typedef struct packed {
    logic [11:0] addr;
    logic        we;
    logic [31:0] data;
  } acc_t;

  logic        clk;
  logic        iReset;
  logic        iCmd_Valid;
  logic        oCmd_Ready;
  logic        iCmd_Write;
  logic [11:0] iCmd_Address;
  logic [7:0]  iCmd_Length;
`ifdef PE_DMEM_BURST_STRIDE_EN
  logic [7:0]  cmd_stride;
`endif
  logic        iWr_Valid;
  logic        oWr_Ready;
  logic [31:0] iWr_Data;
  logic        oRd_Valid;
  logic        iRd_Ready;
  logic [31:0] oRd_Data;
  logic        oBusy;
  logic        oDone;
  logic        oBus_Valid;
  logic        oBus_Write_Enable;
  logic [11:0] oBus_Address;
  logic [31:0] oBus_Write_Data;
  logic [31:0] bus_rdata;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  acc_t        exp_acc [$];
  logic [31:0] exp_rd  [$];

  int checks;
  int failures;
  int cyc;
  int pop_cnt;
  int last_pop_cyc;
  int outst;
  logic rdy_mode;
  logic [3:0] rdy_pat;
  int pidx;

  pe_dmem_burst_ctrl #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (12),
    .LEN_WIDTH  (8)
  ) dut (
    .iClk              (clk),
    .iReset            (iReset),
    .iCmd_Valid        (iCmd_Valid),
    .oCmd_Ready        (oCmd_Ready),
    .iCmd_Write        (iCmd_Write),
    .iCmd_Address      (iCmd_Address),
    .iCmd_Length       (iCmd_Length),
`ifdef PE_DMEM_BURST_STRIDE_EN
    .iCmd_Stride       (cmd_stride),
`endif
    .iWr_Valid         (iWr_Valid),
    .oWr_Ready         (oWr_Ready),
    .iWr_Data          (iWr_Data),
    .oRd_Valid         (oRd_Valid),
    .iRd_Ready         (iRd_Ready),
    .oRd_Data          (oRd_Data),
    .oBusy             (oBusy),
    .oDone             (oDone),
    .oBus_Valid        (oBus_Valid),
    .oBus_Write_Enable (oBus_Write_Enable),
    .oBus_Address      (oBus_Address),
    .oBus_Write_Data   (oBus_Write_Data),
    .iBus_Read_Data    (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Port-A memory with one-cycle registered read data.
  always @(posedge clk) begin
    if (oBus_Valid) begin
      if (oBus_Write_Enable) mem[oBus_Address[11:2]] <= oBus_Write_Data;
      else                   bus_rdata <= mem[oBus_Address[11:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: bus accesses and read pops are compared against the scoreboard queues.
  always @(negedge clk) begin : monitor
    acc_t a;
    logic [31:0] d;
    logic issue, pop;
    if (!iReset) begin
      issue = oBus_Valid && !oBus_Write_Enable;
      pop   = oRd_Valid && iRd_Ready;
      if (oBus_Valid) begin
        if (exp_acc.size() == 0) begin
          check_eq("bus_access_expected", 32'(oBus_Address), 32'hFFFF_FFFF);
        end else begin
          a = exp_acc.pop_front();
          check_eq("bus_addr", 32'(oBus_Address), 32'(a.addr));
          check_eq("bus_we", 32'(oBus_Write_Enable), 32'(a.we));
          if (a.we) check_eq("bus_wdata", oBus_Write_Data, a.data);
        end
      end
      if (pop) begin
        if (exp_rd.size() == 0) begin
          check_eq("rd_word_expected", oRd_Data, 32'hDEAD_BEEF);
        end else begin
          d = exp_rd.pop_front();
          check_eq("rd_data", oRd_Data, d);
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      outst = outst + int'(issue) - int'(pop);
      if (issue) check_eq("rd_outstanding_le2", 32'(outst <= 2), 32'd1);
    end
  end

  initial begin
    iRd_Ready = 1'b1;
    pidx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode) begin
        iRd_Ready = rdy_pat[pidx];
        pidx = (pidx + 1) % 4;
      end else begin
        iRd_Ready = 1'b1;
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [11:0] a, input int n);
    iCmd_Valid   = 1'b1;
    iCmd_Write   = we;
    iCmd_Address = a;
    iCmd_Length  = 8'(n);
    check_eq("cmd_ready", 32'(oCmd_Ready), 32'd1);
    @(posedge clk);
    #1;
    iCmd_Valid = 1'b0;
  endtask

  task automatic do_write(input logic [11:0] base, input int n, input logic [31:0] d0,
                          input int stride);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = (base & 12'hFFC) + 12'(i * 4 * stride);
      exp_acc.push_back('{addr: a, we: 1'b1, data: d0 + 32'(i)});
      ref_mem[a[11:2]] = d0 + 32'(i);
    end
`ifdef PE_DMEM_BURST_STRIDE_EN
    cmd_stride = 8'(stride);
`endif
    send_cmd(1'b1, base, n);
    check_eq("wr_busy", 32'(oBusy), 32'd1);
    for (int i = 0; i < n; i++) begin
      iWr_Valid = 1'b1;
      iWr_Data  = d0 + 32'(i);
      check_eq("wr_ready", 32'(oWr_Ready), 32'd1);
      @(posedge clk);
      #1;
    end
    iWr_Valid = 1'b0;
    check_eq("wr_done_timing", 32'(oDone), 32'd1);
    @(posedge clk);
    #1;
    check_eq("wr_cmd_ready_after_done", 32'(oCmd_Ready), 32'd1);
  endtask

  task automatic do_read(input logic [11:0] base, input int n, input int stride,
                         input logic chk_lat);
    logic [11:0] a;
    logic found;
    for (int i = 0; i < n; i++) begin
      a = (base & 12'hFFC) + 12'(i * 4 * stride);
      exp_acc.push_back('{addr: a, we: 1'b0, data: 32'd0});
      exp_rd.push_back(ref_mem[a[11:2]]);
    end
`ifdef PE_DMEM_BURST_STRIDE_EN
    cmd_stride = 8'(stride);
`endif
    send_cmd(1'b0, base, n);
    if (chk_lat) begin
      check_eq("rd_lat_c1_issue", 32'(oBus_Valid), 32'd1);
      check_eq("rd_lat_c1_valid", 32'(oRd_Valid), 32'd0);
      @(posedge clk); #1;
      check_eq("rd_lat_c2_valid", 32'(oRd_Valid), 32'd0);
      @(posedge clk); #1;
      check_eq("rd_lat_c3_valid", 32'(oRd_Valid), 32'd1);
    end
    found = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (oDone) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("rd_done_seen", 32'(found), 32'd1);
    if (found) check_eq("rd_done_after_last_pop", 32'(cyc), 32'(last_pop_cyc + 1));
    check_eq("rd_all_popped", 32'(exp_rd.size()), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rd_cmd_ready_after_done", 32'(oCmd_Ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_cmd_ready"}, 32'(oCmd_Ready), 32'd1);
    check_eq({pfx, "_busy"},      32'(oBusy), 32'd0);
    check_eq({pfx, "_done"},      32'(oDone), 32'd0);
    check_eq({pfx, "_wr_ready"},  32'(oWr_Ready), 32'd0);
    check_eq({pfx, "_rd_valid"},  32'(oRd_Valid), 32'd0);
    check_eq({pfx, "_bus_valid"}, 32'(oBus_Valid), 32'd0);
    check_eq({pfx, "_bus_we"},    32'(oBus_Write_Enable), 32'd0);
    check_eq({pfx, "_bus_addr"},  32'(oBus_Address), 32'd0);
    check_eq({pfx, "_bus_wdata"}, oBus_Write_Data, 32'd0);
    check_eq({pfx, "_rd_data"},   oRd_Data, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic found;
    checks = 0; failures = 0; pop_cnt = 0; last_pop_cyc = -1; outst = 0;
    rdy_mode = 1'b0; rdy_pat = 4'b1001;
    iReset = 1'b0; iCmd_Valid = 1'b0; iCmd_Write = 1'b0; iCmd_Address = '0;
    iCmd_Length = '0; iWr_Valid = 1'b0; iWr_Data = 32'h5A5A_5A5A;
`ifdef PE_DMEM_BURST_STRIDE_EN
    cmd_stride = 8'd1;
`endif
    #1 iReset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("rst");
    iReset = 1'b0;
    @(posedge clk); #1;

    do_write(12'h010, 4, 32'h0000_00A0, 1);
    do_read(12'h010, 4, 1, 1'b1);

    do_write(12'h020, 2, 32'h0000_00B0, 1);
    rdy_mode = 1'b1; pidx = 0;
    do_read(12'h013, 6, 1, 1'b0);
    rdy_mode = 1'b0;

    send_cmd(1'b0, 12'h040, 0);
    check_eq("len0_done", 32'(oDone), 32'd1);
    check_eq("len0_no_bus", 32'(oBus_Valid), 32'd0);
    @(posedge clk); #1;
    check_eq("len0_cmd_ready", 32'(oCmd_Ready), 32'd1);

    do_write(12'hFFC, 2, 32'h0000_0055, 1);
    do_read(12'hFFC, 2, 1, 1'b0);

    // Reset after two of five words have been delivered.
    for (int i = 0; i < 5; i++) begin
      exp_acc.push_back('{addr: 12'h010 + 12'(4 * i), we: 1'b0, data: 32'd0});
      exp_rd.push_back(ref_mem[4 + i]);
    end
    pop_cnt = 0;
    send_cmd(1'b0, 12'h010, 5);
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (pop_cnt >= 2) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check_eq("rst_mid_two_pops", 32'(found), 32'd1);
    iReset = 1'b1;
    exp_acc.delete();
    exp_rd.delete();
    outst = 0;
    #2;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    iReset = 1'b0;
    @(posedge clk); #1;
    do_read(12'h010, 2, 1, 1'b0);

`ifdef PE_DMEM_BURST_STRIDE_EN
    do_write(12'h000, 3, 32'h0000_00C0, 3);
    do_read(12'h000, 3, 3, 1'b0);
    do_read(12'h00C, 3, 0, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_drained", 32'(exp_acc.size() + exp_rd.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_dmem_burst_ctrl.md
# pe_dmem_burst_ctrl

Bus-side burst engine that drives port A of the PE data memory. Accepts a single host command (base byte address, word count, direction), then streams words into memory from a valid/ready write channel or out of memory onto a valid/ready read channel. Absorbs the memory's one-cycle registered read latency and host backpressure with a 2-entry read buffer. Core-side port B is untouched; same-word conflicts between port A and port B in one cycle are undefined and must be avoided by software.

## Interface
- DATA_WIDTH, 32, word width; a multiple of 8
- ADDR_WIDTH, 12, bus byte-address width (matches PE data-memory bus address)
- LEN_WIDTH, 8, command word-count width
- iClk  in  1  system clock, rising edge
- iReset  in  1  **asynchronous, active-high** reset
- iCmd_Valid / oCmd_Ready  in/out  1  command handshake; oCmd_Ready=1 only in IDLE
- iCmd_Write  in  1  1=host-to-memory, 0=memory-to-host
- iCmd_Address  in  ADDR_WIDTH  base byte address; bits [1:0] ignored
- iCmd_Length  in  LEN_WIDTH  word count
- iWr_Valid / oWr_Ready / iWr_Data  in/out/in  1/1/DATA_WIDTH  write stream
- oRd_Valid / iRd_Ready / oRd_Data  out/in/out  1/1/DATA_WIDTH  read stream
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle completion pulse
- oBus_Valid, oBus_Write_Enable  out  1  to memory port A
- oBus_Address  out  ADDR_WIDTH  to memory port A; bits [1:0]=0
- oBus_Write_Data  out  DATA_WIDTH  to memory port A
- iBus_Read_Data  in  DATA_WIDTH  from memory port A; valid the cycle after a read issue, held until the next read

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE: on iCmd_Valid, latch address (word-aligned), length, direction. Length 0 → DONE directly, no memory access. Otherwise → WRITE or READ.
- WRITE: oWr_Ready=1; oBus_Valid=oBus_Write_Enable=iWr_Valid (combinational); oBus_Write_Data=iWr_Data. Each handshake: address += 4, remaining -= 1. Handshake on last word → DONE.
- READ: issue a read (oBus_Valid=1, WE=0) when issued < length and (fifo_count + inflight − pop) < 2. Data returning the next cycle is pushed into the 2-entry FIFO. oRd_Valid = FIFO non-empty. After the final word pops → DONE.
- DONE: oDone=1 for one cycle → IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH and wraps silently from the top word to 0.
- Idle outputs: oBus_Valid=0, oBus_Write_Enable=0, oWr_Ready=0.

## Timing
- Reset values: state IDLE; oCmd_Ready=1; oBusy, oDone, oWr_Ready, oRd_Valid, oBus_Valid, oBus_Write_Enable=0; oBus_Address, oBus_Write_Data, oRd_Data=0; FIFO empty; inflight=0.
- Command accepted at edge E0. First memory access is in the cycle after E0.
- Write throughput: 1 word/cycle while iWr_Valid=1.
- Read latency: issue in cycle 1; memory data in cycle 2; oRd_Valid in cycle 3. Throughput is 1 word/cycle when iRd_Ready=1.
- Backpressure: a held iRd_Ready=0 stalls issue once 2 words are buffered or in flight. No word is ever dropped or duplicated.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- oDone asserts the cycle after the final write handshake, or the cycle after the final read pop. oCmd_Ready returns the cycle after oDone.
- Reset mid-burst: immediate return to IDLE. FIFO and in-flight state are discarded; memory contents are not altered by the reset.

## Configuration
- PE_DMEM_BURST_STRIDE_EN defined: adds input iCmd_Stride [7:0], latched with the command. The address advances by iCmd_Stride×4 bytes per word. Stride 0 repeatedly accesses the base word.
- Not defined: port absent; stride fixed at 1 word.

## Structure
- Shared package/defines hold:
  - state encoding (IDLE/WRITE/READ/DONE)
  - FIFO depth constant (2)
  - default widths tied to the PE data-width and data-memory address-width defines
- Sub-module pe_dmem_burst_rdfifo: 2-entry synchronous FIFO with push, pop, count, and async active-high reset.

## Test plan
- Write burst: addr 0x010, length 4, data 0xA0..0xA3 with iWr_Valid held → oBus_Address 0x010,0x014,0x018,0x01C on consecutive cycles with WE=1; oDone the cycle after the 4th handshake.
- Read back the same region with iRd_Ready=1 → oRd_Valid from cycle 3; data 0xA0..0xA3 on consecutive cycles; oDone after the last pop.
- Read length 6 with iRd_Ready toggling 1,0,0,1 → at most 2 outstanding words; output order exact, no loss.
- Length 0 command → no oBus_Valid; oDone the cycle after acceptance.
- Wrap: addr 0xFFC, length 2 (ADDR_WIDTH=12) → accesses at 0xFFC then 0x000.
- Assert iReset during a read after 2 of 5 words → all outputs at reset values next cycle; a new command is accepted normally. With PE_DMEM_BURST_STRIDE_EN and stride 3, addr 0 → accesses at 0x000, 0x00C, 0x018.
